// File: rtl/mem_responder_if.sv
// mem_if: memory-side request/response bus between the cache (master) and mem_responder (slave).
interface mem_if;
  logic        mem_renable;
  logic        mem_wenable;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  modport master (output mem_renable, mem_wenable, mem_addr, mem_wdata, input mem_rdata, mem_ready, mem_err);
  modport slave (input mem_renable, mem_wenable, mem_addr, mem_wdata, output mem_rdata, mem_ready, mem_err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory model with programmable latency and one-cycle mem_ready pulse.
// Define MEM_RANGE_CHECK_EN to flag out-of-range word indices via mem_err instead of wrapping.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1
) (
  input logic   clk,
  input logic   rst,
  mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [29:0] idx;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] mem [DEPTH_WORDS];
  logic        req, cap, direct, go_resp, e_wr, in_range, unused_bits;
  logic [29:0] e_idx;
  logic [31:0] e_wd;
  // With LATENCY = 1 the response edge is the capture edge, so act on the live request.
  always_comb begin
    req = bus.mem_renable | bus.mem_wenable;
    cap = req && state != WAIT;
    direct = cap && LATENCY == 1;
    go_resp = direct || (state == WAIT && cnt == 4'd0);
    e_wr = direct ? bus.mem_wenable : op_wr;
    e_idx = direct ? bus.mem_addr[31:2] : idx;
    e_wd = direct ? bus.mem_wdata : wd;
  end
`ifdef MEM_RANGE_CHECK_EN
  assign in_range = e_idx < 30'(DEPTH_WORDS);
  assign unused_bits = ^bus.mem_addr[1:0];
`else
  assign in_range = 1'b1;
  assign unused_bits = ^{bus.mem_addr[1:0], e_idx[29:AW]};
`endif
  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = ready;
  assign bus.mem_err = err;
  // Storage lives in the reset block only so that no write can commit while rst is high.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      idx <= '0;
      wd <= '0;
      rdata <= '0;
      ready <= 1'b0;
      err <= 1'b0;
    end else begin
      ready <= go_resp;
      err <= go_resp && !in_range;
      if (go_resp && !e_wr) rdata <= in_range ? mem[e_idx[AW-1:0]] : '0;
      if (go_resp && e_wr && in_range) mem[e_idx[AW-1:0]] <= e_wd;
      if (cap) begin
        op_wr <= bus.mem_wenable;
        idx <= bus.mem_addr[31:2];
        wd <= bus.mem_wdata;
        state <= LATENCY == 1 ? RESP : WAIT;
        cnt <= 4'(LATENCY - 2);
      end else if (state == WAIT) begin
        state <= cnt == 4'd0 ? RESP : WAIT;
        cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end else
        state <= IDLE;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed main-memory model and controller answering the cache's memory-side request port (mem_renable / mem_wenable / mem_addr / mem_wdata → mem_rdata). It sits below the L2 cache, serving block refills as sequences of single-word reads and write-through stores. It adds a programmable access latency and a one-cycle mem_ready completion pulse. All state is registered in the clk domain.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words of storage; power of two, ≥ 8
- LATENCY, 1, cycles from request capture to response; legal range 1..15
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- mem_renable  in  1  read request
- mem_wenable  in  1  write request
- mem_addr  in  32  byte address; word index = mem_addr[31:2]; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, registered, valid while mem_ready = 1
- mem_ready  out  1  one-cycle completion pulse for the captured request
- mem_err  out  1  out-of-range flag, valid with mem_ready

## Operation
- Reset values: mem_rdata = 0, mem_ready = 0, mem_err = 0, FSM = IDLE, latency counter = 0.
- Storage array is not cleared by reset.
- FSM states:
  - IDLE: on an edge with mem_renable | mem_wenable, capture the op, word index and wdata.
    - LATENCY = 1: go directly to RESP.
    - LATENCY > 1: go to WAIT with counter = LATENCY − 2.
  - WAIT: decrement the counter each edge; go to RESP when it reaches 0.
  - RESP: mem_ready = 1 for this single cycle.
    - A request present on the RESP-exit edge is captured as in IDLE (back-to-back).
    - Otherwise return to IDLE.
- Write: the array is updated on the edge entering RESP; mem_rdata is unchanged.
- Read: mem_rdata is loaded from the array on the edge entering RESP.
- Both mem_renable and mem_wenable high: treated as a write; no read data returned.
- Requests arriving in WAIT or on the entering-RESP edge are ignored. The initiator must hold its request stable until it sees mem_ready.
- Address wrap: word index is taken modulo DEPTH_WORDS unless range checking is compiled in (see Configuration).
- Reset mid-operation: the in-flight request is dropped.
  - A write whose RESP edge has not occurred is not committed.
  - No mem_ready pulse is produced.

## Timing
- Capture edge E0. mem_ready rises on edge E0+LATENCY−1 and falls on edge E0+LATENCY.
- LATENCY = 1 behaves like a synchronous RAM: response registered on the capture edge and visible in the following cycle.
- Sustained throughput is one word per LATENCY cycles. An 8-word refill completes in 8·LATENCY cycles when the initiator presents each next address in the cycle its previous mem_ready is high.
- Read-after-write to the same word, back-to-back, returns the new data.
- mem_err is 0 whenever mem_ready is 0.

## Configuration
- MEM_RANGE_CHECK_EN defined:
  - Requests with word index ≥ DEPTH_WORDS still take LATENCY cycles and pulse mem_ready.
  - mem_err = 1 with that pulse.
  - Reads return mem_rdata = 0.
  - Writes are discarded.
- MEM_RANGE_CHECK_EN undefined:
  - The index wraps modulo DEPTH_WORDS.
  - mem_err is tied to 0.

## Test plan
- Reset check: assert rst mid-WAIT with LATENCY = 4 → mem_ready, mem_err and mem_rdata go to 0 immediately; a subsequent read of the target address shows the old contents (write not committed).
- Write/read, LATENCY = 1: write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0043 → mem_rdata = 0xDEADBEEF in the cycle after the read capture; mem_ready pulses exactly once per request.
- Latency count, LATENCY = 3: read held from edge E0 → mem_ready high only between edges E0+2 and E0+3.
- Back-to-back burst: 8 reads at 0x100..0x11C with preloaded values i·0x11 → eight mem_ready pulses with data 0x00..0x77 in order, done in 8·LATENCY cycles.
- Simultaneous enables: mem_renable = mem_wenable = 1, wdata = 0x1234_5678 at 0x8 → word 2 is written; a later read returns 0x1234_5678.
- Out of range, DEPTH_WORDS = 1024: read 0x0000_1000 →
  - MEM_RANGE_CHECK_EN defined: mem_err = 1 and mem_rdata = 0.
  - MEM_RANGE_CHECK_EN undefined: returns the contents of word 0, mem_err = 0.
